// File: rtl/proc_ctrl_fsm.sv
// Instruction sequencer for the 16-bit simple processor.
// Fetches into IR and sequences T0..T3 bus selects and register load enables.
module proc_ctrl_fsm (
  input  logic        clock,
  input  logic        resetn,
  input  logic        run,
  input  logic [15:0] din,
  output logic [15:0] ir,
  output logic [3:0]  sel,
  output logic [7:0]  r_in,
  output logic        a_in,
  output logic        g_in,
  output logic        addsub,
  output logic        done
);

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVT = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  localparam logic [3:0] SEL_DIN = 4'd8;
  localparam logic [3:0] SEL_G   = 4'd9;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] ir_q;

  logic [2:0] op;
  logic [2:0] rx;
  logic [2:0] ry;
  logic       imm;
  logic [3:0] src_sel;
  logic [7:0] rx_1h;
  logic       is_mv, is_mvt, is_alu;

  assign op      = ir_q[15:13];
  assign imm     = ir_q[12];
  assign rx      = ir_q[11:9];
  assign ry      = ir_q[2:0];
  assign src_sel = imm ? SEL_DIN : {1'b0, ry};
  assign rx_1h   = 8'd1 << rx;
  assign is_mv   = (op == OP_MV);
  assign is_mvt  = (op == OP_MVT);
  assign is_alu  = (op == OP_ADD) || (op == OP_SUB);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= T0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == T0 && run)
        ir_q <= din;
    end
  end

  always_comb begin
    state_d = state_q;
    sel     = 4'd0;
    r_in    = 8'd0;
    a_in    = 1'b0;
    g_in    = 1'b0;
    addsub  = 1'b0;
    done    = 1'b0;
    case (state_q)
      T0: begin
        if (run)
          state_d = T1;
      end
      T1: begin
        state_d = T0;
        unique case (1'b1)
          is_mv: begin
            sel  = src_sel;
            r_in = rx_1h;
            done = 1'b1;
          end
          is_mvt: begin
            sel  = SEL_DIN;
            r_in = rx_1h;
            done = 1'b1;
          end
          is_alu: begin
            sel     = {1'b0, rx};
            a_in    = 1'b1;
            state_d = T2;
          end
          default: done = 1'b1;
        endcase
      end
      T2: begin
        sel     = src_sel;
        g_in    = 1'b1;
        addsub  = (op == OP_SUB);
        state_d = T3;
      end
      T3: begin
        sel     = SEL_G;
        r_in    = rx_1h;
        done    = 1'b1;
        state_d = T0;
      end
      default: state_d = T0;
    endcase
    // Hold the bus quiet while reset is asserted, whatever the decode says.
    if (!resetn) begin
      sel    = 4'd0;
      r_in   = 8'd0;
      a_in   = 1'b0;
      g_in   = 1'b0;
      addsub = 1'b0;
      done   = 1'b0;
    end
  end

  assign ir = ir_q;

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Bench for proc_ctrl_fsm: a per-instruction schedule model
// checked against the DUT every cycle, plus literal spot checks.
module tb_proc_ctrl_fsm;

  logic        clock = 1'b0;
  logic        resetn;
  logic        run;
  logic [15:0] din;
  logic [15:0] ir;
  logic [3:0]  sel;
  logic [7:0]  r_in;
  logic        a_in, g_in, addsub, done;

  proc_ctrl_fsm dut (
    .clock  (clock),
    .resetn (resetn),
    .run    (run),
    .din    (din),
    .ir     (ir),
    .sel    (sel),
    .r_in   (r_in),
    .a_in   (a_in),
    .g_in   (g_in),
    .addsub (addsub),
    .done   (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    int sel;
    int r_in;
    int a_in;
    int g_in;
    int addsub;
    int done;
  } cyc_t;

  cyc_t q[$];
  int   m_ir;
  int   total = 0;
  int   bad   = 0;

  function automatic cyc_t mk(int s, int r, int a, int g, int as, int d);
    cyc_t c;
    c.sel = s; c.r_in = r; c.a_in = a;
    c.g_in = g; c.addsub = as; c.done = d;
    return c;
  endfunction

  // Cycle-by-cycle outputs an instruction word must produce after fetch.
  function automatic void expand(int w);
    int op, rxv, src;
    op  = (w >> 13) & 7;
    rxv = (w >> 9) & 7;
    src = ((w >> 12) & 1) ? 8 : (w & 7);
    if (op == 0) begin
      q.push_back(mk(src, 1 << rxv, 0, 0, 0, 1));
    end else if (op == 1) begin
      q.push_back(mk(8, 1 << rxv, 0, 0, 0, 1));
    end else if (op == 2 || op == 3) begin
      q.push_back(mk(rxv, 0, 1, 0, 0, 0));
      q.push_back(mk(src, 0, 0, 1, (op == 3) ? 1 : 0, 0));
      q.push_back(mk(9, 1 << rxv, 0, 0, 0, 1));
    end else begin
      q.push_back(mk(0, 0, 0, 0, 0, 1));
    end
  endfunction

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    cyc_t e;
    e = (q.size() == 0) ? mk(0, 0, 0, 0, 0, 0) : q[0];
    chk("ir", int'(ir), m_ir);
    chk("sel", int'(sel), e.sel);
    chk("r_in", int'(r_in), e.r_in);
    chk("a_in", int'(a_in), e.a_in);
    chk("g_in", int'(g_in), e.g_in);
    chk("addsub", int'(addsub), e.addsub);
    chk("done", int'(done), e.done);
  endtask

  task automatic model_edge();
    if (q.size() != 0) begin
      void'(q.pop_front());
    end else if (run) begin
      m_ir = int'(din);
      expand(int'(din));
    end
  endtask

  // Called at a negedge: check this cycle, drive inputs, advance one clock.
  task automatic step(input logic r, input logic [15:0] d);
    compare_all();
    run = r;
    din = d;
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  logic [15:0] prog [6] = '{16'h0606, 16'h4402, 16'h7E01,
                            16'h2C00, 16'hE1FF, 16'h5A07};

  initial begin
    resetn = 1'b0;
    run    = 1'b1;
    din    = 16'h13FF;
    m_ir   = 0;
    repeat (2) @(negedge clock);
    chk("rst_ir", int'(ir), 0);
    chk("rst_sel", int'(sel), 0);
    chk("rst_done", int'(done), 0);
    compare_all();
    resetn = 1'b1;
    step(1'b0, 16'h0000);

    // mv R1,#0x1FF
    step(1'b1, 16'h13FF);
    chk("mv_sel", int'(sel), 8);
    chk("mv_rin", int'(r_in), 8'h02);
    chk("mv_done", int'(done), 1);
    step(1'b1, 16'hFFFF);

    // mvt R5,#0xAB, run held high so T0 fetches immediately
    step(1'b1, 16'h3AAB);
    chk("mvt_sel", int'(sel), 8);
    chk("mvt_rin", int'(r_in), 8'h20);
    chk("mvt_done", int'(done), 1);
    step(1'b1, 16'hFFFF);

    // add R2,R5
    step(1'b1, 16'h4405);
    chk("add_t1_sel", int'(sel), 2);
    chk("add_t1_ain", int'(a_in), 1);
    step(1'b1, 16'hFFFF);
    chk("add_t2_sel", int'(sel), 5);
    chk("add_t2_gin", int'(g_in), 1);
    chk("add_t2_as", int'(addsub), 0);
    step(1'b1, 16'hFFFF);
    chk("add_t3_sel", int'(sel), 9);
    chk("add_t3_rin", int'(r_in), 8'h04);
    chk("add_t3_done", int'(done), 1);
    step(1'b1, 16'hFFFF);

    // sub R0,#5
    step(1'b1, 16'h7005);
    step(1'b0, 16'h0000);
    chk("sub_t2_sel", int'(sel), 8);
    chk("sub_t2_as", int'(addsub), 1);
    chk("sub_t2_gin", int'(g_in), 1);
    step(1'b0, 16'h0000);
    chk("sub_t3_rin", int'(r_in), 8'h01);
    chk("sub_t3_done", int'(done), 1);
    step(1'b0, 16'h0000);

    // undefined op
    step(1'b1, 16'hA000);
    chk("undef_done", int'(done), 1);
    chk("undef_rin", int'(r_in), 0);
    chk("undef_ain", int'(a_in), 0);
    chk("undef_gin", int'(g_in), 0);
    step(1'b0, 16'h0000);

    // model-checked table, mixing idle gaps and back-to-back issue
    for (int i = 0; i < 6; i++) begin
      step(1'b1, prog[i]);
      while (q.size() != 0) step(1'b0, 16'h0000);
    end

    // reset in T2 of an add aborts it
    step(1'b1, 16'h4405);
    step(1'b0, 16'h0000);
    compare_all();
    resetn = 1'b0;
    #1;
    q.delete();
    m_ir = 0;
    chk("abort_ir", int'(ir), 0);
    chk("abort_gin", int'(g_in), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_sel", int'(sel), 0);
    @(negedge clock);
    compare_all();
    resetn = 1'b1;
    repeat (4) step(1'b0, 16'h0000);
    compare_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
